beat_timebase: RTL and testbench
================================

BEAT_TIMEBASE -- requirements
Module: beat_timebase

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 500000, the number of consecutive stable cycles needed to accept a button level change.
REQ-002 SHALL have parameter BEAT_DIV, default 25000000, the number of clk cycles per beat at normal speed.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port btn_play, input, 1 bit: raw asynchronous play/pause button.
REQ-006 SHALL have port btn_slow, input, 1 bit: raw asynchronous slow-speed button.
REQ-007 SHALL have port btn_mode, input, 1 bit: raw asynchronous mode button (0 = user play, 1 = auto play).
REQ-008 SHALL have port play, output, 1 bit: run/pause level consumed by the beat-index stage.
REQ-009 SHALL have port slow, output, 1 bit: half-speed level.
REQ-010 SHALL have port mode, output, 1 bit: mode level.
REQ-011 SHALL have port beat_en, output, 1 bit: one-cycle beat-advance strobe for the beat-index stage.

Function
REQ-012 SHALL pass each button through a 2-FF synchronizer, then a debouncer, then a rising-edge one-pulse.
REQ-013 Debouncer SHALL count consecutive cycles in which the synced level differs from the debounced level, clear the count on any agreeing cycle, and flip the debounced level when the count reaches DEB_CYCLES.
REQ-014 Debounced rising edge SHALL produce exactly one 1-cycle pulse; falling edges produce none; a held button produces no repeat pulses.
REQ-015 Latency: with btn held high from edge 1, the corresponding output SHALL change at edge DEB_CYCLES+3.
REQ-016 Play pulse SHALL toggle play; slow pulse SHALL toggle slow.
REQ-017 Mode pulse SHALL toggle mode, force play to 0, and clear the beat counter.
REQ-018 Mode and play pulses in the same cycle: mode rule only, so play = 0.
REQ-019 Beat counter SHALL be 28-bit with limit L = BEAT_DIV normally and 2*BEAT_DIV when slow = 1.
REQ-020 While play && mode: the counter SHALL increment each cycle; when counter >= L-1 it SHALL load 0 and beat_en SHALL be 1 in the next cycle only.
REQ-021 Beat spacing SHALL be exactly L cycles in steady state.
REQ-022 A slow change SHALL take effect on the next compare; a switch to normal with counter >= BEAT_DIV-1 SHALL wrap on the next edge.
REQ-023 While !play || !mode: the counter SHALL hold its value and beat_en SHALL be 0.
REQ-024 Resuming from pause SHALL continue from the held count, with no immediate strobe.

Reset
REQ-025 Reset SHALL clear synchronizers, debounced levels, debounce counts and beat counter, and drive play = slow = mode = beat_en = 0.
REQ-026 Reset asserted mid-debounce or mid-beat SHALL discard all progress; no pulse or strobe SHALL be emitted on release.

Configuration
REQ-027 With macro BEAT_TIMEBASE_DEBOUNCE_EN defined, the debouncer of REQ-013 SHALL be present.
REQ-028 Without BEAT_TIMEBASE_DEBOUNCE_EN, the synced level SHALL feed the one-pulse directly, giving latency 3 edges; DEB_CYCLES is then unused.

Structure
REQ-029 Shared package SHALL hold the DEB_CYCLES/BEAT_DIV defaults and the beat counter width (28).
REQ-030 Sub-module btn_conditioner (sync + debounce + one-pulse) SHALL be instantiated three times.

Verification (DEB_CYCLES=4, BEAT_DIV=10)
REQ-031 Reset, then btn_mode high 10 cycles -> mode=1 at edge 7, play stays 0, beat_en never 1.
REQ-032 mode=1, then btn_play pulse -> play=1; beat_en pulses every 10 cycles, first one 10 cycles after play rises.
REQ-033 Running, then btn_play glitch high 3 cycles -> no toggle; a later 10-cycle press -> play=0 and the counter held; re-press -> the next strobe arrives at the remaining count.
REQ-034 Running, then slow press -> spacing becomes 20; release-press again with counter=15 -> beat_en on the following cycle, then spacing 10.
REQ-035 btn_mode and btn_play rising in the same cycle while running -> mode toggles, play=0, counter=0.
REQ-036 Reset asserted at counter=7 -> all outputs 0 immediately; no beat_en after release.

Source files
------------

// File: rtl/beat_timebase_pkg.sv
// Shared defaults and beat-counter helpers for the beat timebase.
package beat_timebase_pkg;

  localparam int unsigned DEB_CYCLES_DEF = 500000;
  localparam int unsigned BEAT_DIV_DEF   = 25000000;
  localparam int          CNT_W          = 28;

  // Terminal count (limit minus one) for the beat counter; slow doubles the period.
  function automatic logic [CNT_W-1:0] beat_limit_m1(input logic slow_i, input int unsigned div_i);
    logic [31:0] lim;
    lim = slow_i ? (div_i << 1) : div_i;
    return CNT_W'(lim - 32'd1);
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw button -> 2-FF sync -> optional debounce (BEAT_TIMEBASE_DEBOUNCE_EN) -> rising-edge pulse.
// Latency from input edge to pulse-driven register change: DEB_CYCLES+3 edges, or 3 without debounce.
module btn_conditioner
  import beat_timebase_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q;
  logic lvl;
  logic prev_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef BEAT_TIMEBASE_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic          deb_q, deb_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // Any cycle that agrees with the accepted level restarts the stability count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == DW'(DEB_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl = deb_q;
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= lvl;
    end
  end

  assign pulse_o = lvl & ~prev_q;

endmodule

// File: rtl/beat_timebase.sv
// Button-driven play/slow/mode levels and the beat_en strobe; debounce enabled by BEAT_TIMEBASE_DEBOUNCE_EN.
// beat_en is registered: it rises the cycle after the counter wraps.
module beat_timebase
  import beat_timebase_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned BEAT_DIV   = BEAT_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_play,
  input  logic btn_slow,
  input  logic btn_mode,
  output logic play,
  output logic slow,
  output logic mode,
  output logic beat_en
);

  logic pls_play, pls_slow, pls_mode;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_play (
    .clk_i(clk), .reset_i(reset), .btn_i(btn_play), .pulse_o(pls_play)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_slow (
    .clk_i(clk), .reset_i(reset), .btn_i(btn_slow), .pulse_o(pls_slow)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
    .clk_i(clk), .reset_i(reset), .btn_i(btn_mode), .pulse_o(pls_mode)
  );

  logic             play_q, play_d;
  logic             slow_q, slow_d;
  logic             mode_q, mode_d;
  logic             beat_q, beat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_m1;

  always_comb begin
    play_d = play_q ^ pls_play;
    slow_d = slow_q ^ pls_slow;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    beat_d = 1'b0;
    lim_m1 = beat_limit_m1(slow_q, BEAT_DIV);
    // A mode change wins over a simultaneous play toggle and restarts the beat.
    if (pls_mode) begin
      mode_d = ~mode_q;
      play_d = 1'b0;
      cnt_d  = '0;
    end else if (play_q && mode_q) begin
      if (cnt_q >= lim_m1) begin
        cnt_d  = '0;
        beat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      play_q <= 1'b0;
      slow_q <= 1'b0;
      mode_q <= 1'b0;
      beat_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      play_q <= play_d;
      slow_q <= slow_d;
      mode_q <= mode_d;
      beat_q <= beat_d;
      cnt_q  <= cnt_d;
    end
  end

  assign play    = play_q;
  assign slow    = slow_q;
  assign mode    = mode_q;
  assign beat_en = beat_q;

endmodule

// File: tb/tb_beat_timebase.sv
// Scoreboard bench for beat_timebase with DEB_CYCLES=4, BEAT_DIV=10; timing adapts to BEAT_TIMEBASE_DEBOUNCE_EN.
module tb_beat_timebase;

  localparam int DEB = 4;
  localparam int DIV = 10;
`ifdef BEAT_TIMEBASE_DEBOUNCE_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = 3;
`endif

  localparam int K_MODE = 0;
  localparam int K_PLAY = 1;
  localparam int K_SLOW = 2;
  localparam int K_BEAT = 3;
  localparam int B_BOTH = 4;

  typedef struct {
    int   cyc;
    int   kind;
    logic val;
  } evt_t;

  evt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  bit   mon_en = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_play = 1'b0;
  logic btn_slow = 1'b0;
  logic btn_mode = 1'b0;
  logic play, slow, mode, beat_en;
  logic prev_play, prev_slow, prev_mode;

  beat_timebase #(.DEB_CYCLES(DEB), .BEAT_DIV(DIV)) dut (
    .clk(clk), .reset(reset),
    .btn_play(btn_play), .btn_slow(btn_slow), .btn_mode(btn_mode),
    .play(play), .slow(slow), .mode(mode), .beat_en(beat_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic string kname(input int k);
    case (k)
      K_MODE:  return "mode";
      K_PLAY:  return "play";
      K_SLOW:  return "slow";
      default: return "beat_en";
    endcase
  endfunction

  // Sorted insert so expectations can be pushed in any order.
  function automatic void expect_evt(input int cyc, input int kind, input logic val);
    evt_t e;
    int   i;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = val;
    i = 0;
    while (i < exp_q.size() &&
           (exp_q[i].cyc < cyc || (exp_q[i].cyc == cyc && exp_q[i].kind <= kind)))
      i++;
    exp_q.insert(i, e);
  endfunction

  task automatic mon_check(input int kind, input logic val);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got %b at cycle %0d, required no change", kname(kind), val, edge_n);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != edge_n || e.kind != kind || e.val !== val)
      begin
        errors++;
        $display("FAIL event: got %s=%b at cycle %0d, required %s=%b at cycle %0d",
                 kname(kind), val, edge_n, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every output change or strobe must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (mode !== prev_mode) mon_check(K_MODE, mode);
      if (play !== prev_play) mon_check(K_PLAY, play);
      if (slow !== prev_slow) mon_check(K_SLOW, slow);
      if (beat_en !== 1'b0)   mon_check(K_BEAT, beat_en);
    end
    prev_mode = mode;
    prev_play = play;
    prev_slow = slow;
  end

  task automatic set_btn(input int which, input logic v);
    case (which)
      K_MODE:  btn_mode = v;
      K_PLAY:  btn_play = v;
      K_SLOW:  btn_slow = v;
      default: begin btn_mode = v; btn_play = v; end
    endcase
  endtask

  task automatic at_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  task automatic press(input int which, input int len);
    set_btn(which, 1'b1);
    repeat (len) @(negedge clk);
    set_btn(which, 1'b0);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, edge %0d", edge_n);
    $fatal(1);
  end

  initial begin
    int p, q, r, s, t, u, v, w;
    p = 30 + LAT;
    q = 73 + LAT;
    r = 100 + LAT;
    s = 130 + LAT;
    t = 162 + LAT;
    u = 190 + LAT;
    v = 210 + LAT;
    w = 230 + LAT;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_play", 32'(play), 0);
    check_val("reset_slow", 32'(slow), 0);
    check_val("reset_mode", 32'(mode), 0);
    check_val("reset_beat_en", 32'(beat_en), 0);
    check_val("reset_cnt", 32'(dut.cnt_q), 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Mode press alone: mode rises, play and beat_en stay quiet.
    expect_evt(5 + LAT, K_MODE, 1'b1);
    at_edge(5);
    press(K_MODE, 10);

    // Play: first strobe 10 cycles after play rises, then every 10.
    expect_evt(p, K_PLAY, 1'b1);
    for (int m = 1; m <= 4; m++) expect_evt(p + DIV * m, K_BEAT, 1'b1);
    at_edge(30);
    press(K_PLAY, 10);
`ifdef BEAT_TIMEBASE_DEBOUNCE_EN
    at_edge(50);
    press(K_PLAY, 3);
`endif

    // Pause 43 cycles into the run leaves the count at 3.
    expect_evt(q, K_PLAY, 1'b0);
    at_edge(73);
    press(K_PLAY, 10);
    at_edge(95);
    check_val("held_cnt", 32'(dut.cnt_q), 3);

    // Resume continues from 3: next strobe 7 cycles later.
    expect_evt(r, K_PLAY, 1'b1);
    for (int m = 0; m < 3; m++) expect_evt(r + 7 + DIV * m, K_BEAT, 1'b1);
    at_edge(100);
    press(K_PLAY, 10);

    // Slow with count 3: next wrap after count 19.
    expect_evt(s, K_SLOW, 1'b1);
    expect_evt(s + 17, K_BEAT, 1'b1);
    at_edge(130);
    press(K_SLOW, 10);

    // Back to normal at count 15: immediate wrap, then spacing 10.
    expect_evt(t, K_SLOW, 1'b0);
    for (int m = 0; m < 3; m++) expect_evt(t + 1 + DIV * m, K_BEAT, 1'b1);
    at_edge(162);
    set_btn(K_SLOW, 1'b1);
    at_edge(t);
    check_val("cnt_at_normal", 32'(dut.cnt_q), 15);
    at_edge(172);
    set_btn(K_SLOW, 1'b0);

    // Mode and play together while running: mode wins, play off, count cleared.
    expect_evt(u, K_MODE, 1'b0);
    expect_evt(u, K_PLAY, 1'b0);
    at_edge(190);
    set_btn(B_BOTH, 1'b1);
    at_edge(u);
    check_val("cnt_after_mode", 32'(dut.cnt_q), 0);
    at_edge(200);
    set_btn(B_BOTH, 1'b0);

    // Run again, then reset at count 7.
    expect_evt(v, K_MODE, 1'b1);
    at_edge(210);
    press(K_MODE, 10);
    expect_evt(w, K_PLAY, 1'b1);
    at_edge(230);
    press(K_PLAY, 10);
    at_edge(w + 7);
    check_val("cnt_before_reset", 32'(dut.cnt_q), 7);
    expect_evt(w + 8, K_MODE, 1'b0);
    expect_evt(w + 8, K_PLAY, 1'b0);
    reset = 1'b1;
    #1;
    check_val("rst_play", 32'(play), 0);
    check_val("rst_slow", 32'(slow), 0);
    check_val("rst_mode", 32'(mode), 0);
    check_val("rst_beat_en", 32'(beat_en), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check_val("pending_events", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
